led_sequencer: RTL and testbench
================================

# led_sequencer

Mode controller and shared PWM scheduler for the board's two RGB LEDs. It takes the two debounced button levels and steps each LED independently through OFF, color-cycle and breathe modes. It generates the color rotation and the fade ramp, and time-shares one free-running PWM counter across all six color channels. It sits between the button debouncer and the LED pins and replaces per-LED ad-hoc PWM and shift logic in the top level.

## Interface
- `COLOR_DIV`, default 62500000: clocks per color step (2 Hz at 125 MHz); must be ≥ 2.
- `FADE_DIV`, default 244140: clocks per fade step (about 1 s full breathe at 8 bit); must be ≥ 1.
- `PWM_WIDTH`, default 8: PWM counter and duty width.
- `CYCLE_DUTY`, default 127: fixed duty used in CYCLE mode; must be < 2^PWM_WIDTH.

Ports:
- `clk` in 1: 125 MHz system clock; the only clock.
- `resetn` in 1: asynchronous, active-low reset.
- `btn_db` in 2: debounced button levels, active high, synchronous to `clk`; bit n controls LED n.
- `led0_rgb` out 3: {r,g,b} for LED 0, active high, registered.
- `led1_rgb` out 3: {r,g,b} for LED 1, active high, registered.
- `mode0` out 2: current mode of LED 0.
- `mode1` out 2: current mode of LED 1.

## Operation
- **Press detect:** `btn_q` holds `btn_db` delayed by one cycle. `press[n] = btn_db[n] & ~btn_q[n]`. Releases are ignored.
- **Per-LED mode FSM:** OFF(0) → CYCLE(1) → BREATHE(2) → OFF on each press. Encoding 3 is unreachable; if it is ever seen, the FSM goes to OFF on the next clock.
- **Simultaneous presses:** both LEDs advance in the same cycle, independently.
- **Color register:** shared 3-bit one-hot, order blue(001) → green(010) → red(100) → blue. It advances when `color_cnt` reaches COLOR_DIV-1; `color_cnt` then wraps to 0. Rotation runs in every mode.
- **Fade level:** shared PWM_WIDTH-bit level plus a direction bit. On each fade tick (`fade_cnt` = FADE_DIV-1):
  - counting up, it increments;
  - counting down, it decrements;
  - on the tick where it reaches 2^PWM_WIDTH-1 the direction flips to down; on reaching 0 it flips to up;
  - it never wraps.
- **Duty per LED:**
  - OFF: 0.
  - CYCLE: CYCLE_DUTY.
  - BREATHE: fade level.
- **PWM:** shared free-running `pwm_cnt` of PWM_WIDTH bits, wraps at 2^PWM_WIDTH-1 → 0. Channel on iff `pwm_cnt < duty`. Duty 0 is never on; maximum duty is on 2^W-1 of every 2^W cycles.
- **Output:** `ledN_rgb = color & {3{pwm_on}}`. OFF forces 000.
- **Reset** (asynchronous assert, takes effect immediately):
  - `led*_rgb` = 000, `mode*` = OFF;
  - color = 001;
  - fade level = 0, direction up;
  - all counters 0, `btn_q` = 00.
- **Reset released mid-press:** a button already held at release counts as a press on the first clock after deassertion, because `btn_q` = 0.

## Timing
- Press latency: with `btn_db` rising before edge k, `mode` updates at edge k and `led_rgb` reflects the new mode at edge k+1.
- The color step is visible on `led_rgb` one cycle after the `color_cnt` terminal cycle. The fade step behaves the same way.
- The PWM period is exactly 2^PWM_WIDTH cycles, with no phase reset on mode change.
- A press in the same cycle as a color or fade tick applies both; neither is dropped.
- Both LEDs in BREATHE are in phase, since the fade level is shared.

## Configuration
- `LED_SEQ_BREATHE_EN` defined: full FSM OFF → CYCLE → BREATHE → OFF, and the fade generator is present.
- Not defined:
  - the fade counter and level logic are removed;
  - the FSM becomes OFF → CYCLE → OFF;
  - mode 2 is unreachable and treated like 3 (→ OFF).

## Structure
- Package `led_seq_pkg`:
  - mode constants MODE_OFF, MODE_CYCLE, MODE_BREATHE (2-bit);
  - color constants COLOR_BLUE, COLOR_GREEN, COLOR_RED, COLOR_RESET;
  - a 2-bit mode typedef.
- Sub-module `led_seq_channel`, instantiated twice:
  - inputs: `press`, shared color, fade level, `pwm_cnt`;
  - logic: mode FSM, duty mux, compare, output register;
  - outputs: `mode` and `rgb`.
- The top of the block owns edge detect, the color, fade and PWM counters, and the shared registers.

## Test plan
Bench parameters: COLOR_DIV=8, FADE_DIV=2, PWM_WIDTH=4, CYCLE_DUTY=7.
1. **Reset:** hold `resetn`=0 with random `btn_db` → `led*_rgb`=000 and `mode*`=0. Release → after 8 clocks color=010 internally while LEDs stay 000.
2. **One press:** pulse `btn_db[0]` once → `mode0`=1 one edge later. Then, over 16 clocks, `led0_rgb` equals the current color for exactly 7 cycles. `led1_rgb` stays 000.
3. **Mode walk:** press button 0 three times → `mode0` sequence 1, 2, 0. In mode 2, the on-count per 16-cycle window tracks the fade ramp 0…15…0, flipping at 15 and at 0 without wrap.
4. **Simultaneous press:** both buttons rise on the same cycle as a color tick → both modes go to 1 in the same cycle, and the color advances in that same cycle.
5. **Held button:** hold `btn_db[1]`=1 for 100 cycles → exactly one mode advance.
6. **Mid-operation reset:** assert `resetn` while in BREATHE → immediate 000 outputs and `mode`=0. Build without `LED_SEQ_BREATHE_EN` → two presses give `mode` 1 then 0.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared mode and color definitions for the dual RGB LED sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_CYCLE   = 2'd1,
        MODE_BREATHE = 2'd2
    } mode_e;

    localparam logic [2:0] COLOR_BLUE  = 3'b001;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_RED   = 3'b100;
    localparam logic [2:0] COLOR_RESET = COLOR_BLUE;

    // Any non one-hot value recovers to blue.
    function automatic logic [2:0] next_color(input logic [2:0] c);
        case (c)
            COLOR_BLUE:  next_color = COLOR_GREEN;
            COLOR_GREEN: next_color = COLOR_RED;
            default:     next_color = COLOR_BLUE;
        endcase
    endfunction

endpackage

// File: rtl/led_seq_channel.sv
// One LED channel: press-driven mode FSM, duty select, PWM compare, output register.
// LED_SEQ_BREATHE_EN enables the BREATHE mode step in the FSM.
module led_seq_channel
    import led_seq_pkg::*;
#(
    parameter int PWM_WIDTH  = 8,
    parameter int CYCLE_DUTY = 127
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 press,
    input  logic [2:0]           color,
    input  logic [PWM_WIDTH-1:0] fade_lvl,
    input  logic [PWM_WIDTH-1:0] pwm_cnt,
    output logic [1:0]           mode,
    output logic [2:0]           rgb
);

    localparam logic [PWM_WIDTH-1:0] CYCLE_DUTY_W = PWM_WIDTH'(CYCLE_DUTY);

    mode_e                mode_q, mode_d;
    logic [2:0]           rgb_q, rgb_d;
    logic [PWM_WIDTH-1:0] duty;

    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_OFF: begin
                if (press) mode_d = MODE_CYCLE;
            end
            MODE_CYCLE: begin
`ifdef LED_SEQ_BREATHE_EN
                if (press) mode_d = MODE_BREATHE;
`else
                if (press) mode_d = MODE_OFF;
`endif
            end
`ifdef LED_SEQ_BREATHE_EN
            MODE_BREATHE: begin
                if (press) mode_d = MODE_OFF;
            end
`endif
            default: mode_d = MODE_OFF;
        endcase
    end

    // Duty comes from the current mode, so a press shows on the pins one clock after the mode changes.
    always_comb begin
        duty = '0;
        case (mode_q)
            MODE_CYCLE:   duty = CYCLE_DUTY_W;
            MODE_BREATHE: duty = fade_lvl;
            default:      duty = '0;
        endcase
        rgb_d = color & {3{pwm_cnt < duty}};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q <= MODE_OFF;
            rgb_q  <= 3'b000;
        end else begin
            mode_q <= mode_d;
            rgb_q  <= rgb_d;
        end
    end

    assign mode = mode_q;
    assign rgb  = rgb_q;

endmodule

// File: rtl/led_sequencer.sv
// Dual RGB LED mode controller with shared color rotation, fade ramp and PWM counter.
// LED_SEQ_BREATHE_EN adds the fade generator and the BREATHE mode.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int COLOR_DIV  = 62500000,
    parameter int FADE_DIV   = 244140,
    parameter int PWM_WIDTH  = 8,
    parameter int CYCLE_DUTY = 127
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] btn_db,
    output logic [2:0] led0_rgb,
    output logic [2:0] led1_rgb,
    output logic [1:0] mode0,
    output logic [1:0] mode1
);

    localparam int COLOR_CW = $clog2(COLOR_DIV);

    logic [1:0]           btn_q, btn_d;
    logic [1:0]           press;
    logic [COLOR_CW-1:0]  color_cnt_q, color_cnt_d;
    logic [2:0]           color_q, color_d;
    logic                 color_tick;
    logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_WIDTH-1:0] fade_lvl;

    // A button held through reset release reads as a press because btn_q starts at zero.
    always_comb begin
        btn_d       = btn_db;
        press       = btn_db & ~btn_q;
        color_tick  = (color_cnt_q == COLOR_CW'(COLOR_DIV - 1));
        color_cnt_d = color_tick ? '0 : color_cnt_q + 1'b1;
        color_d     = color_tick ? next_color(color_q) : color_q;
        pwm_cnt_d   = pwm_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_q       <= 2'b00;
            color_cnt_q <= '0;
            color_q     <= COLOR_RESET;
            pwm_cnt_q   <= '0;
        end else begin
            btn_q       <= btn_d;
            color_cnt_q <= color_cnt_d;
            color_q     <= color_d;
            pwm_cnt_q   <= pwm_cnt_d;
        end
    end

`ifdef LED_SEQ_BREATHE_EN
    localparam int FADE_CW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PWM_WIDTH-1:0] LVL_MAX = {PWM_WIDTH{1'b1}};
    localparam logic [PWM_WIDTH-1:0] LVL_ONE = PWM_WIDTH'(1);

    logic [FADE_CW-1:0]   fade_cnt_q, fade_cnt_d;
    logic [PWM_WIDTH-1:0] fade_lvl_q, fade_lvl_d;
    logic                 fade_up_q, fade_up_d;
    logic                 fade_tick;

    // Direction flips on the same tick the level lands on an end, so the ramp never wraps.
    always_comb begin
        fade_tick  = (fade_cnt_q == FADE_CW'(FADE_DIV - 1));
        fade_cnt_d = fade_tick ? '0 : fade_cnt_q + 1'b1;
        fade_lvl_d = fade_lvl_q;
        fade_up_d  = fade_up_q;
        if (fade_tick) begin
            if (fade_up_q) begin
                if (fade_lvl_q != LVL_MAX) fade_lvl_d = fade_lvl_q + 1'b1;
                if (fade_lvl_q >= LVL_MAX - LVL_ONE) fade_up_d = 1'b0;
            end else begin
                if (fade_lvl_q != '0) fade_lvl_d = fade_lvl_q - 1'b1;
                if (fade_lvl_q <= LVL_ONE) fade_up_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fade_cnt_q <= '0;
            fade_lvl_q <= '0;
            fade_up_q  <= 1'b1;
        end else begin
            fade_cnt_q <= fade_cnt_d;
            fade_lvl_q <= fade_lvl_d;
            fade_up_q  <= fade_up_d;
        end
    end

    assign fade_lvl = fade_lvl_q;
`else
    assign fade_lvl = '0;
`endif

    led_seq_channel #(
        .PWM_WIDTH (PWM_WIDTH),
        .CYCLE_DUTY(CYCLE_DUTY)
    ) u_ch0 (
        .clk     (clk),
        .resetn  (resetn),
        .press   (press[0]),
        .color   (color_q),
        .fade_lvl(fade_lvl),
        .pwm_cnt (pwm_cnt_q),
        .mode    (mode0),
        .rgb     (led0_rgb)
    );

    led_seq_channel #(
        .PWM_WIDTH (PWM_WIDTH),
        .CYCLE_DUTY(CYCLE_DUTY)
    ) u_ch1 (
        .clk     (clk),
        .resetn  (resetn),
        .press   (press[1]),
        .color   (color_q),
        .fade_lvl(fade_lvl),
        .pwm_cnt (pwm_cnt_q),
        .mode    (mode1),
        .rgb     (led1_rgb)
    );

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with small dividers; covers both builds of LED_SEQ_BREATHE_EN.
module tb_led_sequencer;

    localparam int COLOR_DIV  = 8;
    localparam int FADE_DIV   = 2;
    localparam int PWM_WIDTH  = 4;
    localparam int CYCLE_DUTY = 7;

    logic       clk;
    logic       resetn;
    logic [1:0] btn_db;
    logic [2:0] led0_rgb, led1_rgb;
    logic [1:0] mode0, mode1;

    int total = 0;
    int bad   = 0;
    int cyc;
    int on0;
    logic [2:0] col_before;

    led_sequencer #(
        .COLOR_DIV (COLOR_DIV),
        .FADE_DIV  (FADE_DIV),
        .PWM_WIDTH (PWM_WIDTH),
        .CYCLE_DUTY(CYCLE_DUTY)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .btn_db  (btn_db),
        .led0_rgb(led0_rgb),
        .led1_rgb(led1_rgb),
        .mode0   (mode0),
        .mode1   (mode1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges seen since the last reset release.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int ramp(input int n);
        int r;
        r = n % 30;
        return (r <= 15) ? r : 30 - r;
    endfunction

    function automatic logic [2:0] exp_color(input int edges);
        return 3'b001 << ((edges / 8) % 3);
    endfunction

    // Output after edge e is built from the state left by edge e-1.
    function automatic logic [2:0] exp_rgb(input int e, input logic [1:0] m);
        int s, pwm, duty;
        s    = e - 1;
        pwm  = s % 16;
        duty = (m == 2'd1) ? CYCLE_DUTY : (m == 2'd2) ? ramp(s / 2) : 0;
        return (pwm < duty) ? exp_color(s) : 3'b000;
    endfunction

    function automatic logic [1:0] nxt(input logic [1:0] m);
        case (m)
            2'd0:    return 2'd1;
`ifdef LED_SEQ_BREATHE_EN
            2'd1:    return 2'd2;
`else
            2'd1:    return 2'd0;
`endif
            default: return 2'd0;
        endcase
    endfunction

    task automatic press_btn(input int n);
        btn_db[n] = 1'b1;
        step();
        btn_db[n] = 1'b0;
    endtask

    task automatic win(input int n, input logic [1:0] m0, input logic [1:0] m1, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            check("rgb0", led0_rgb, exp_rgb(cyc, m0));
            check("rgb1", led1_rgb, exp_rgb(cyc, m1));
            if (led0_rgb != 3'b000) cnt++;
        end
    endtask

    initial begin
        resetn = 1'b0;
        btn_db = 2'b00;

        // Reset held with random buttons
        for (int i = 0; i < 4; i++) begin
            btn_db = 2'($urandom);
            step();
            check("rst_rgb0", led0_rgb, 3'b000);
            check("rst_rgb1", led1_rgb, 3'b000);
            check("rst_mode0", mode0, 2'd0);
            check("rst_mode1", mode1, 2'd0);
        end
        btn_db = 2'b00;
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("idle_rgb0", led0_rgb, 3'b000);
            check("idle_rgb1", led1_rgb, 3'b000);
        end
        check("color_after8", dut.color_q, 3'b010);

        // Single press on LED 0
        press_btn(0);
        check("press_mode0", mode0, 2'd1);
        check("press_mode1", mode1, 2'd0);
        win(16, 2'd1, 2'd0, on0);
        check("cycle_on_count", on0, CYCLE_DUTY);

        // Mode walk on LED 0
        press_btn(0);
        check("walk_mode0_b", mode0, nxt(2'd1));
`ifdef LED_SEQ_BREATHE_EN
        win(70, 2'd2, 2'd0, on0);
        press_btn(0);
        check("walk_mode0_c", mode0, 2'd0);
`endif
        win(16, 2'd0, 2'd0, on0);
        check("off_on_count", on0, 0);

        // Simultaneous press on a color tick
        for (int i = 0; i < 16 && (cyc % 8) != 7; i++) step();
        check("align_tick", cyc % 8, 7);
        col_before = dut.color_q;
        check("color_pre_tick", col_before, exp_color(cyc));
        btn_db = 2'b11;
        step();
        btn_db = 2'b00;
        check("sim_mode0", mode0, 2'd1);
        check("sim_mode1", mode1, 2'd1);
        check("color_post_tick", dut.color_q, exp_color(cyc));
        win(16, 2'd1, 2'd1, on0);

        // Held button gives one advance
        btn_db[1] = 1'b1;
        step();
        check("held_first", mode1, nxt(2'd1));
        for (int i = 0; i < 99; i++) step();
        btn_db[1] = 1'b0;
        check("held_end_mode1", mode1, nxt(2'd1));
        check("held_end_mode0", mode0, 2'd1);
        step();
        check("held_release_mode1", mode1, nxt(2'd1));

        // Asynchronous reset while LED 0 is lit
        for (int i = 0; i < 32 && (cyc % 16) != 2; i++) step();
        check("pre_rst_rgb0", led0_rgb, exp_rgb(cyc, 2'd1));
        #2;
        resetn = 1'b0;
        #1;
        check("arst_rgb0", led0_rgb, 3'b000);
        check("arst_rgb1", led1_rgb, 3'b000);
        check("arst_mode0", mode0, 2'd0);
        check("arst_mode1", mode1, 2'd0);

        // Button already held when reset releases
        step();
        btn_db = 2'b10;
        step();
        check("held_in_rst_mode1", mode1, 2'd0);
        resetn = 1'b1;
        step();
        check("rel_press_mode1", mode1, 2'd1);
        check("rel_press_mode0", mode0, 2'd0);
        btn_db = 2'b00;
        step();
        check("rel_hold_mode1", mode1, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
